// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// read-valid strobe, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     clr_err,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     push,
    input  logic                     pull,
    output logic [WIDTH-1:0]         data_out,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wa;
    logic [AW-1:0]    ra;
    logic             pull_ok;
    logic             push_ok;
    logic             ovf_set;
    logic             unf_set;

    // Status flags decode the registered count only, never push/pull.
    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign almost_empty = (count <= CW'(AE_LEVEL));
    assign almost_full  = (count >= CW'(AF_LEVEL));

    // A push into a full FIFO is accepted only when a read frees a slot at the same edge.
    always_comb begin
        pull_ok = pull & ~empty;
        push_ok = push & (~full | pull_ok);
        ovf_set = ~flush & push & ~push_ok;
        unf_set = ~flush & pull & empty;
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && push_ok) begin
            mem[wa] <= data_in;
        end
    end

    // Pointers, occupancy and registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wa       <= '0;
            ra       <= '0;
            count    <= '0;
            data_out <= '0;
            rd_valid <= 1'b0;
        end else if (flush) begin
            wa       <= '0;
            ra       <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pull_ok;
            if (push_ok) begin
                wa <= wa + AW'(1);
            end
            if (pull_ok) begin
                data_out <= mem[ra];
                ra       <= ra + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pull_ok);
        end
    end

    // Sticky error flags; a new error wins over clr_err in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (unf_set) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule
